// File: rtl/snes_pad_scheduler.sv
// Two-pad SNES poll sequencer: timed/requested polls, GBA KEYINPUT merge
// and KEYCNT-style keypad interrupt.
module snes_pad_scheduler #(
  parameter int US_CYCLES = 100,
  parameter int PERIOD_US = 16667,
  parameter int LATCH_US  = 12,
  parameter int GAP_US    = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        poll_req,
  output logic        poll_busy,
  output logic        poll_done,
  output logic        data_latch,
  output logic        data_clock,
  input  logic [1:0]  serial_data,
  output logic [15:0] raw0,
  output logic [15:0] raw1,
  output logic [1:0]  present,
  output logic [9:0]  keyinput,
  input  logic [15:0] keycnt,
  output logic        key_irq
);

  localparam int LAT_N  = LATCH_US * US_CYCLES;
  localparam int GAP_N  = GAP_US * US_CYCLES;
  localparam int PER_N  = PERIOD_US * US_CYCLES;
  localparam int PH_MAX = (LAT_N > GAP_N) ? LAT_N : GAP_N;
  localparam int CW     = $clog2(PH_MAX + 1);
  localparam int TW     = (PER_N > 1) ? $clog2(PER_N) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_GAP, S_CLK_LO, S_CLK_HI, S_UPDATE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          pend_q, pend_d;
  logic [15:0]   sh0_q, sh1_q;
  logic [15:0]   raw0_q, raw1_q;
  logic [1:0]    pres_q;
  logic [9:0]    key_q;
  logic          cprev_q;
  logic          latch_q, clk_q, busy_q, done_q, irq_q;

  logic          start, samp, expire, ev, last;
  logic [1:0]    pres_new;
  logic [9:0]    key_new, sel, hit;
  logic          cond;
  logic          unused_keycnt;

  assign unused_keycnt = ^keycnt[13:10];

  // Raw serial order -> KEYINPUT bit order (L R Dn Up Lf Rt St Se B A)
  function automatic logic [9:0] map_keys(input logic [15:0] r);
    return {r[10], r[11], r[5], r[4], r[6], r[7], r[3], r[2], r[0], r[8]};
  endfunction

  assign expire = (PER_N != 0) && (tmr_q == TW'(PER_N - 1));
  assign ev     = poll_req | expire;
  assign last   = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = last ? cnt_q : cnt_q - CW'(1);
    bit_d   = bit_q;
    pend_d  = pend_q;
    start   = 1'b0;
    samp    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ev || pend_q) begin
          start   = 1'b1;
          state_d = S_LATCH;
          cnt_d   = CW'(LAT_N - 1);
          bit_d   = 4'd0;
        end
      end
      S_LATCH: begin
        if (last) begin
          state_d = S_GAP;
          cnt_d   = CW'(GAP_N - 1);
        end
      end
      S_GAP: begin
        if (last) begin
          state_d = S_CLK_LO;
          cnt_d   = CW'(GAP_N - 1);
        end
      end
      S_CLK_LO: begin
        if (last) begin
          samp    = 1'b1;
          state_d = S_CLK_HI;
          cnt_d   = CW'(GAP_N - 1);
        end
      end
      S_CLK_HI: begin
        if (last) begin
          bit_d   = bit_q + 4'd1;
          cnt_d   = CW'(GAP_N - 1);
          state_d = (bit_q == 4'd15) ? S_UPDATE : S_CLK_LO;
        end
      end
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (start) pend_d = 1'b0;
    else if (state_q != S_IDLE && ev) pend_d = 1'b1;
    tmr_d = (start || expire || PER_N == 0) ? '0 : tmr_q + TW'(1);
  end

  // Frame evaluation straight off the shadows; they are complete
  // from the last CLK_HI through UPDATE.
  always_comb begin
    pres_new = {sh1_q[15:12] == 4'hF, sh0_q[15:12] == 4'hF};
    key_new  = (pres_new[0] ? map_keys(sh0_q) : 10'h3FF)
             & (pres_new[1] ? map_keys(sh1_q) : 10'h3FF);
    sel      = keycnt[9:0];
    hit      = ~key_new & sel;
    cond     = keycnt[15] ? ((hit == sel) && (sel != '0)) : |hit;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tmr_q   <= '0;
      pend_q  <= 1'b0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      raw0_q  <= 16'hFFFF;
      raw1_q  <= 16'hFFFF;
      pres_q  <= 2'b00;
      key_q   <= 10'h3FF;
      cprev_q <= 1'b0;
      latch_q <= 1'b0;
      clk_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tmr_q   <= tmr_d;
      pend_q  <= pend_d;
      if (samp) begin
        sh0_q[bit_q] <= serial_data[0];
        sh1_q[bit_q] <= serial_data[1];
      end
      if (state_q == S_UPDATE) begin
        raw0_q  <= sh0_q;
        raw1_q  <= sh1_q;
        pres_q  <= pres_new;
        key_q   <= key_new;
        cprev_q <= cond;
      end
      latch_q <= (state_d == S_LATCH);
      clk_q   <= (state_d != S_CLK_LO);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_UPDATE);
      irq_q   <= (state_d == S_UPDATE) && keycnt[14] && cond && !cprev_q;
    end
  end

  assign poll_busy  = busy_q;
  assign poll_done  = done_q;
  assign data_latch = latch_q;
  assign data_clock = clk_q;
  assign raw0       = raw0_q;
  assign raw1       = raw1_q;
  assign present    = pres_q;
  assign keyinput   = key_q;
  assign key_irq    = irq_q;

endmodule

// File: tb/tb_snes_pad_scheduler.sv
// Directed bench for snes_pad_scheduler: pad shift-register model,
// request/auto polls, merge, pending collapse, IRQ edge and reset.
module tb_snes_pad_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        poll_req = 1'b0;
  logic        areq = 1'b0;
  logic [15:0] keycnt = 16'h0000;
  logic [15:0] frm0 = 16'hFFFF;
  logic [15:0] frm1 = 16'h0000;
  logic [1:0]  sd;
  logic [4:0]  idx = 5'd0;

  logic        poll_busy, poll_done, data_latch, data_clock, key_irq;
  logic [15:0] raw0, raw1;
  logic [1:0]  present;
  logic [9:0]  keyinput;

  logic        a_busy, a_done, a_latch, a_clk, a_irq;
  logic [15:0] a_raw0, a_raw1;
  logic [1:0]  a_pres;
  logic [9:0]  a_key;

  int checks = 0;
  int errors = 0;
  int falls = 0;
  int dones = 0;
  int irqs = 0;
  time rt[$];

  snes_pad_scheduler #(
    .US_CYCLES(1), .PERIOD_US(0), .LATCH_US(2), .GAP_US(1)
  ) u_dut (
    .clock(clock), .reset(reset), .poll_req(poll_req),
    .poll_busy(poll_busy), .poll_done(poll_done),
    .data_latch(data_latch), .data_clock(data_clock),
    .serial_data(sd), .raw0(raw0), .raw1(raw1),
    .present(present), .keyinput(keyinput),
    .keycnt(keycnt), .key_irq(key_irq)
  );

  snes_pad_scheduler #(
    .US_CYCLES(1), .PERIOD_US(300), .LATCH_US(2), .GAP_US(1)
  ) u_auto (
    .clock(clock), .reset(reset), .poll_req(areq),
    .poll_busy(a_busy), .poll_done(a_done),
    .data_latch(a_latch), .data_clock(a_clk),
    .serial_data(2'b00), .raw0(a_raw0), .raw1(a_raw1),
    .present(a_pres), .keyinput(a_key),
    .keycnt(16'h0000), .key_irq(a_irq)
  );

  always #5 clock = ~clock;

  // Pad model: latch reloads bit 0, each clock rise shifts the next bit out
  always @(posedge data_latch) idx = 5'd0;
  always @(posedge data_clock) if (!data_latch) idx = idx + 5'd1;
  always_comb begin
    sd[0] = (idx < 5'd16) ? frm0[idx[3:0]] : 1'b0;
    sd[1] = (idx < 5'd16) ? frm1[idx[3:0]] : 1'b0;
  end

  always @(negedge data_clock) falls++;
  always @(negedge clock) begin
    if (poll_done) dones++;
    if (key_irq) irqs++;
  end
  always @(posedge a_latch) rt.push_back($time);

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic run_poll(output int bc, output int dc, output logic l0);
    bc = 0;
    dc = 0;
    poll_req = 1'b1;
    @(negedge clock);
    poll_req = 1'b0;
    l0 = data_latch;
    for (int i = 0; i < 100; i++) begin
      if (poll_busy) bc++;
      if (poll_done) dc++;
      @(negedge clock);
      if (!poll_busy) break;
    end
  endtask

  initial begin
    int bc, dc, f0, i0, d0;
    int dn, rises, td, tr;
    logic l0, pl;
    int n0;
    time tq;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (100) @(negedge clock);
    check("rst_latch", data_latch, 1'b0);
    check("rst_clock", data_clock, 1'b1);
    check("rst_key", keyinput, 10'h3FF);
    check("rst_present", present, 2'b00);
    check("rst_raw0", raw0, 16'hFFFF);
    check("rst_busy", poll_busy, 1'b0);
    check("rst_falls", falls, 0);

    frm0 = 16'hFFFE;
    frm1 = 16'h0000;
    f0 = falls;
    run_poll(bc, dc, l0);
    check("p1_latency", l0, 1'b1);
    check("p1_busy_len", bc, 36);
    check("p1_done_len", dc, 1);
    check("p1_falls", falls - f0, 16);
    check("p1_raw0", raw0, 16'hFFFE);
    check("p1_raw1", raw1, 16'h0000);
    check("p1_present", present, 2'b01);
    check("p1_key", keyinput, 10'h3FD);

    frm0 = 16'hFEFF;
    frm1 = 16'hFBFF;
    run_poll(bc, dc, l0);
    check("p2_raw1", raw1, 16'hFBFF);
    check("p2_present", present, 2'b11);
    check("p2_key", keyinput, 10'h1FE);

    dn = 0; rises = 0; td = -1; tr = -1; pl = data_latch;
    for (int c = 0; c < 120; c++) begin
      if (poll_done) begin
        dn++;
        if (td < 0) td = c;
      end
      if (data_latch && !pl) begin
        rises++;
        if (rises == 2) tr = c;
      end
      pl = data_latch;
      poll_req = (c == 0 || c == 5 || c == 10 || c == 20);
      @(negedge clock);
    end
    poll_req = 1'b0;
    check("pend_dones", dn, 2);
    check("pend_rises", rises, 2);
    check("pend_gap", tr - td, 2);
    check("pend_key", keyinput, 10'h1FE);

    n0 = rt.size();
    for (int i = 0; i < 800 && rt.size() < n0 + 2; i++) @(negedge clock);
    if (rt.size() >= n0 + 2)
      check("auto_period", int'((rt[n0+1] - rt[n0]) / 10), 300);
    else
      check("auto_timeout", rt.size(), n0 + 2);
    repeat (100) @(negedge clock);
    n0 = rt.size();
    tq = $time;
    areq = 1'b1;
    @(negedge clock);
    areq = 1'b0;
    for (int i = 0; i < 800 && rt.size() < n0 + 2; i++) @(negedge clock);
    if (rt.size() >= n0 + 2) begin
      check("auto_req_start", int'(rt[n0] - tq), 5);
      check("auto_reload", int'((rt[n0+1] - rt[n0]) / 10), 300);
    end else
      check("auto_req_timeout", rt.size(), n0 + 2);

    frm1 = 16'h0000;
    keycnt = 16'hC003;
    frm0 = 16'hFEFE;
    i0 = irqs;
    run_poll(bc, dc, l0);
    check("irq_and_first", irqs - i0, 1);
    check("irq_key_ab", keyinput, 10'h3FC);
    i0 = irqs;
    run_poll(bc, dc, l0);
    check("irq_held", irqs - i0, 0);
    frm0 = 16'hFFFF;
    i0 = irqs;
    run_poll(bc, dc, l0);
    check("irq_release", irqs - i0, 0);
    frm0 = 16'hFEFE;
    i0 = irqs;
    run_poll(bc, dc, l0);
    check("irq_repress", irqs - i0, 1);
    frm0 = 16'hFEFF;
    i0 = irqs;
    run_poll(bc, dc, l0);
    check("irq_and_partial", irqs - i0, 0);
    keycnt = 16'h4003;
    i0 = irqs;
    run_poll(bc, dc, l0);
    check("irq_or_a", irqs - i0, 1);

    poll_req = 1'b1;
    @(negedge clock);
    poll_req = 1'b0;
    for (int i = 0; i < 20 && data_clock; i++) @(negedge clock);
    check("mid_in_clk_lo", data_clock, 1'b0);
    d0 = dones;
    reset = 1'b1;
    #1;
    check("mid_latch", data_latch, 1'b0);
    check("mid_clock", data_clock, 1'b1);
    check("mid_busy", poll_busy, 1'b0);
    check("mid_key", keyinput, 10'h3FF);
    @(negedge clock);
    reset = 1'b0;
    f0 = falls;
    repeat (60) @(negedge clock);
    check("mid_no_update", dones - d0, 0);
    check("mid_no_falls", falls - f0, 0);
    check("mid_raw0", raw0, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
